// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war round controller.
//   tow_round_state_t : round sequencer states (DARK, LIT, OVER)
//   TOW_DIR_LEFT/RIGHT: encoding of the mv_left direction qualifier
package tow_pkg;

    typedef enum logic [1:0] {
        DARK = 2'd0,
        LIT  = 2'd1,
        OVER = 2'd2
    } tow_round_state_t;

    localparam logic TOW_DIR_LEFT  = 1'b1;
    localparam logic TOW_DIR_RIGHT = 1'b0;

endpackage

// File: rtl/tow_round_ctrl_if.sv
// Bundle between the round controller and its surroundings.
//   pbl, pbr  : raw push-buttons (left, right), asynchronous
//   win       : a player has won (from the light-position datapath)
//   lamp_en   : lit phase active
//   mv_valid  : one-cycle move strobe, qualified by mv_left / mv_jump
//   tie       : one-cycle simultaneous-push strobe
// The master drives buttons/win; the slave (controller) drives the rest.
interface tow_round_ctrl_if;

    logic pbl;
    logic pbr;
    logic win;
    logic lamp_en;
    logic mv_valid;
    logic mv_left;
    logic mv_jump;
    logic tie;

    modport master (
        output pbl, pbr, win,
        input  lamp_en, mv_valid, mv_left, mv_jump, tie
    );

    modport slave (
        input  pbl, pbr, win,
        output lamp_en, mv_valid, mv_left, mv_jump, tie
    );

endinterface

// File: rtl/tow_btn_sync.sv
// Push-button conditioning: 2-flop synchroniser followed by a rising-edge
// detector.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   raw  : raw asynchronous button level
//   rise : one-cycle pulse on a synchronised 0->1 transition
module tow_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    logic       s1;
    logic       s2;
    logic       prev;
    logic [1:0] fill;

    // The synchroniser flops come out of reset at 0, which is not the real
    // button level. 'fill' marks when s2 carries a genuinely sampled value;
    // until then prev is held at 1 so a button held through reset does not
    // look like a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b1;
            fill <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
            prev <= fill[1] ? s2 : 1'b1;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/tow_round_ctrl.sv
// Round sequencer and push arbiter for the tug-of-war game.
// Times the dark and lit phases, synchronises both buttons, arbitrates who
// pushed first (or tie / jump) and emits registered one-cycle strobes.
//   DARK_CYCLES : clocks of dark phase before going lit (>= 1)
//   LIT_CYCLES  : clocks the lit phase waits for a push (>= 1)
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   bus         : tow_round_ctrl_if.slave (buttons, win, lamp and strobes)
// Build option: define TOW_JUMP_PENALTY_EN to penalise pushes during DARK
// with a jump move toward the offender's opponent; otherwise DARK pushes
// are ignored and mv_jump stays 0.
module tow_round_ctrl
    import tow_pkg::*;
#(
    parameter int unsigned DARK_CYCLES = 8,
    parameter int unsigned LIT_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             rst,
    tow_round_ctrl_if.slave  bus
);

    localparam int unsigned CNT_MAX = (DARK_CYCLES > LIT_CYCLES) ? DARK_CYCLES : LIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DARK_RELOAD = CNT_W'(DARK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIT_RELOAD  = CNT_W'(LIT_CYCLES - 1);

    tow_round_state_t state;
    logic [CNT_W-1:0] cnt;
    logic             rise_l;
    logic             rise_r;
    logic             lamp_en;
    logic             mv_valid;
    logic             mv_left;
    logic             mv_jump;
    logic             tie;

    tow_btn_sync u_sync_l (.clk(clk), .rst(rst), .raw(bus.pbl), .rise(rise_l));
    tow_btn_sync u_sync_r (.clk(clk), .rst(rst), .raw(bus.pbr), .rise(rise_r));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DARK;
            cnt      <= DARK_RELOAD;
            lamp_en  <= 1'b0;
            mv_valid <= 1'b0;
            mv_left  <= 1'b0;
            mv_jump  <= 1'b0;
            tie      <= 1'b0;
        end else begin
            mv_valid <= 1'b0;
            mv_left  <= 1'b0;
            mv_jump  <= 1'b0;
            tie      <= 1'b0;
            if (bus.win) begin
                state   <= OVER;
                lamp_en <= 1'b0;
            end else begin
                case (state)
                    DARK: begin
`ifdef TOW_JUMP_PENALTY_EN
                        // A push while dark outranks the dark timeout.
                        if (rise_l || rise_r) begin
                            cnt <= DARK_RELOAD;
                            if (rise_l && rise_r) begin
                                tie <= 1'b1;
                            end else begin
                                mv_valid <= 1'b1;
                                mv_jump  <= 1'b1;
                                mv_left  <= rise_r ? TOW_DIR_LEFT : TOW_DIR_RIGHT;
                            end
                        end else
`endif
                        if (cnt == '0) begin
                            state   <= LIT;
                            cnt     <= LIT_RELOAD;
                            lamp_en <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    LIT: begin
                        if (rise_l || rise_r) begin
                            state   <= DARK;
                            cnt     <= DARK_RELOAD;
                            lamp_en <= 1'b0;
                            if (rise_l && rise_r) begin
                                tie <= 1'b1;
                            end else begin
                                mv_valid <= 1'b1;
                                mv_left  <= rise_l ? TOW_DIR_LEFT : TOW_DIR_RIGHT;
                            end
                        end else if (cnt == '0) begin
                            state   <= DARK;
                            cnt     <= DARK_RELOAD;
                            lamp_en <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    OVER: begin
                        lamp_en <= 1'b0;
                    end
                    default: begin
                        state   <= DARK;
                        cnt     <= DARK_RELOAD;
                        lamp_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.lamp_en  = lamp_en;
    assign bus.mv_valid = mv_valid;
    assign bus.mv_left  = mv_left;
    assign bus.mv_jump  = mv_jump;
    assign bus.tie      = tie;

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Self-checking bench for tow_round_ctrl with DARK_CYCLES=4, LIT_CYCLES=8.
// A behavioural model (button sample history + phase timer) is compared
// against the DUT after every clock; directed scenarios add literal checks.
module tb_tow_round_ctrl;

    localparam int DC = 4;
    localparam int LC = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   strobe_cnt = 0;
    int   lamp_cnt   = 0;

    always #5 clk = ~clk;

    tow_round_ctrl_if bus ();

    tow_round_ctrl #(.DARK_CYCLES(DC), .LIT_CYCLES(LC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.lamp_en;
            1:       return bus.mv_valid;
            default: return bus.tie;
        endcase
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    initial begin
        bit hl[$];
        bit hr[$];
        int phase;  // 0 dark, 1 lit, 2 over
        int t;      // cycles elapsed in current phase
        bit el, er, w;
        bit e_mv, e_left, e_jump, e_tie, e_lamp;
        phase = 0; t = 0;
        e_mv = 0; e_left = 0; e_jump = 0; e_tie = 0; e_lamp = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                hl.delete(); hr.delete();
                phase = 0; t = 0;
                e_mv = 0; e_left = 0; e_jump = 0; e_tie = 0; e_lamp = 0;
            end else begin
                // FSM sees a rise of the level sampled two edges back
                el = (hl.size() >= 3) && hl[$-1] && !hl[$-2];
                er = (hr.size() >= 3) && hr[$-1] && !hr[$-2];
                hl.push_back(bus.pbl);
                hr.push_back(bus.pbr);
                if (hl.size() > 3) void'(hl.pop_front());
                if (hr.size() > 3) void'(hr.pop_front());
                w = bus.win;
                e_mv = 0; e_left = 0; e_jump = 0; e_tie = 0;
                if (phase == 2) begin
                end else if (w) begin
                    phase = 2;
                end else if (phase == 1) begin
                    if (el || er) begin
                        if (el && er) e_tie = 1;
                        else begin e_mv = 1; e_left = el; end
                        phase = 0; t = 0;
                    end else if (t == LC - 1) begin
                        phase = 0; t = 0;
                    end else t++;
                end else begin
`ifdef TOW_JUMP_PENALTY_EN
                    if (el || er) begin
                        if (el && er) e_tie = 1;
                        else begin e_mv = 1; e_jump = 1; e_left = er; end
                        t = 0;
                    end else
`endif
                    if (t == DC - 1) begin
                        phase = 1; t = 0;
                    end else t++;
                end
                e_lamp = (phase == 1);
            end
            #1;
            check("lamp_en", bus.lamp_en, e_lamp);
            check("mv_valid", bus.mv_valid, e_mv);
            check("tie", bus.tie, e_tie);
            if (e_mv || !rst) begin
                check("mv_left", bus.mv_left, e_left);
                check("mv_jump", bus.mv_jump, e_jump);
            end
        end
    end

    // strobe / lamp activity counters for directed literal checks
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.mv_valid || bus.tie) strobe_cnt++;
            if (bus.lamp_en) lamp_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait until signal 'which' equals val; n = edges waited, -1 on timeout.
    task automatic wait_for(input int which, input logic val, input int max, output int n);
        int k = 0;
        bit hit = 0;
        while (!hit && k < max) begin
            @(posedge clk); #1; k++;
            if (sig(which) === val) hit = 1;
        end
        n = hit ? k : -1;
    endtask

    // Raise buttons at a negedge for one sampling edge, then wait for 'which'
    // to go high; n counts edges starting with the one that samples the press.
    task automatic pulse_and_wait(input bit l, input bit r, input int which, input int max,
                                  output int n);
        int k = 0;
        bit hit = 0;
        @(negedge clk);
        bus.pbl = l; bus.pbr = r;
        while (!hit && k < max) begin
            @(posedge clk); #1; k++;
            if (k == 1) begin bus.pbl = 1'b0; bus.pbr = 1'b0; end
            if (sig(which) === 1'b1) hit = 1;
        end
        n = hit ? k : -1;
    endtask

    initial begin
        int n;
        int s0;
        int l0;
        rst = 1'b1; bus.pbl = 1'b0; bus.pbr = 1'b0; bus.win = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_lamp", bus.lamp_en, 0);
        check("reset_mv_valid", bus.mv_valid, 0);
        rst = 1'b1;

        // idle rounds: lit after 4 clocks, for 8 clocks, no strobes
        s0 = strobe_cnt;
        wait_for(0, 1'b1, 20, n);  check("first_lit_delay", n, DC);
        wait_for(0, 1'b0, 20, n);  check("lit_length", n, LC);
        wait_for(0, 1'b1, 20, n);  check("second_dark_length", n, DC);
        check("idle_no_strobes", strobe_cnt - s0, 0);

        // left press during LIT
        pulse_and_wait(1, 0, 1, 10, n);
        check("left_latency", n, 3);
        check("left_mv_left", bus.mv_left, 1);
        check("left_mv_jump", bus.mv_jump, 0);
        check("left_lamp_drop", bus.lamp_en, 0);
        @(posedge clk); #1;
        check("left_one_cycle", bus.mv_valid, 0);

        // simultaneous press during LIT
        wait_for(0, 1'b1, 20, n);
        pulse_and_wait(1, 1, 2, 10, n);
        check("tie_latency", n, 3);
        check("tie_no_move", bus.mv_valid, 0);
        check("tie_lamp_drop", bus.lamp_en, 0);

        // right press during DARK (immediately after the tie)
`ifdef TOW_JUMP_PENALTY_EN
        pulse_and_wait(0, 1, 1, 10, n);
        check("jump_latency", n, 3);
        check("jump_mv_left", bus.mv_left, 1);
        check("jump_mv_jump", bus.mv_jump, 1);
        wait_for(0, 1'b1, 20, n);
        check("jump_restart_dark", n, DC);
`else
        s0 = strobe_cnt;
        pulse_and_wait(0, 1, 0, 20, n);
        check("dark_press_lit_timing", n, DC);
        check("dark_press_ignored", strobe_cnt - s0, 0);
`endif

        // right button held through reset release
        @(negedge clk);
        rst = 1'b0; bus.pbr = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        s0 = strobe_cnt;
        repeat (20) @(negedge clk);
        check("held_through_reset", strobe_cnt - s0, 0);
        bus.pbr = 1'b0;
        wait_for(0, 1'b0, 20, n);
        wait_for(0, 1'b1, 20, n);
        pulse_and_wait(0, 1, 1, 10, n);
        check("repress_latency", n, 3);
        check("repress_mv_left", bus.mv_left, 0);

        // win in the same cycle a LIT push resolves
        wait_for(0, 1'b1, 20, n);
        s0 = strobe_cnt;
        @(negedge clk); bus.pbl = 1'b1;
        @(posedge clk); #1; bus.pbl = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.win = 1'b1;
        @(posedge clk); #1;
        check("win_suppress", bus.mv_valid, 0);
        check("win_lamp", bus.lamp_en, 0);
        @(negedge clk); bus.win = 1'b0;
        l0 = lamp_cnt;
        for (int i = 0; i < 6; i++) begin
            pulse_and_wait(i[0], ~i[0], 1, 5, n);
            repeat (3) @(negedge clk);
        end
        check("over_no_strobes", strobe_cnt - s0, 0);
        check("over_lamp_off", lamp_cnt - l0, 0);

        // reset leaves OVER; then an asynchronous abort mid-LIT
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        wait_for(0, 1'b1, 20, n);
        check("after_over_lit_delay", n, DC);
        #2 rst = 1'b0;
        #1 check("async_abort_lamp", bus.lamp_en, 0);
        @(negedge clk); @(negedge clk); rst = 1'b1;

        // randomized play, checked by the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            case ($urandom_range(0, 15))
                0: bus.pbl = ~bus.pbl;
                1: bus.pbr = ~bus.pbr;
                2: begin
                    if (!bus.pbl && !bus.pbr) begin bus.pbl = 1'b1; bus.pbr = 1'b1; end
                    else begin bus.pbl = 1'b0; bus.pbr = 1'b0; end
                end
                default: ;
            endcase
            bus.win = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #3 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        bus.pbl = 1'b0; bus.pbr = 1'b0; bus.win = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
